// File: rtl/iob_eth_mii_loopback.sv
// MII/GMII loopback channel model: TX beats are replayed on RX through a DELAY-stage
// register line, with frame drop, single-beat error injection and saturating statistics.
module iob_eth_mii_loopback #(
    parameter int DATA_W = 4,
    parameter int DELAY  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] tx_d_i,
    input  logic              tx_en_i,
    input  logic              tx_er_i,
    input  logic              drop_i,
    input  logic              inj_en_i,
    input  logic [CNT_W-1:0]  inj_idx_i,
    input  logic [DATA_W-1:0] inj_mask_i,
    input  logic              inj_flag_i,
    output logic [DATA_W-1:0] rx_d_o,
    output logic              rx_dv_o,
    output logic              rx_er_o,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic [CNT_W-1:0]  drop_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1'b1);
        end
        return r;
    endfunction

    state_t                         state_r, state_s;
    logic                           wait_low_r, drop_pend_r;
    logic                           inj_arm_r, inj_flag_r;
    logic [CNT_W-1:0]               inj_idx_r, beat_r;
    logic [DATA_W-1:0]              inj_mask_r;
    logic [CNT_W-1:0]               frame_cnt_r, drop_cnt_r, err_cnt_r;
    logic                           start_s, start_pass_s, start_drop_s, beat_act_s, hit_s;
    logic                           arm_s, flag_s;
    logic [CNT_W-1:0]               idx_s, tgt_s;
    logic [DATA_W-1:0]              mask_s, d0_s;
    logic                           dv0_s, er0_s;
    logic [DELAY-1:0][DATA_W+1:0]   pipe_r;

    // Frame-start qualification; the start beat uses the live injection inputs
    always_comb begin
        start_s      = (state_r == IDLE) && tx_en_i && !wait_low_r;
        start_pass_s = start_s && en_i && !drop_pend_r;
        start_drop_s = start_s && en_i && drop_pend_r;
        beat_act_s   = ((state_r == PASS) && tx_en_i) || start_pass_s;
        if (start_s) begin
            idx_s = CNT_ZERO;
        end else begin
            idx_s = beat_r;
        end
        if (start_pass_s) begin
            arm_s  = inj_en_i;
            tgt_s  = inj_idx_i;
            mask_s = inj_mask_i;
            flag_s = inj_flag_i;
        end else begin
            arm_s  = inj_arm_r;
            tgt_s  = inj_idx_r;
            mask_s = inj_mask_r;
            flag_s = inj_flag_r;
        end
        hit_s = beat_act_s && arm_s && (idx_s == tgt_s);
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_pass_s) begin
                    state_s = PASS;
                end else if (start_drop_s) begin
                    state_s = DROP;
                end else begin
                    state_s = IDLE;
                end
            end
            PASS, DROP: begin
                if (!tx_en_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM output: stage-0 tuple entering the delay line
    always_comb begin
        d0_s  = {DATA_W{1'b0}};
        dv0_s = 1'b0;
        er0_s = 1'b0;
        if (beat_act_s) begin
            dv0_s = 1'b1;
            if (hit_s) begin
                d0_s  = tx_d_i ^ mask_s;
                er0_s = tx_er_i | flag_s;
            end else begin
                d0_s  = tx_d_i;
                er0_s = tx_er_i;
            end
        end else begin
            d0_s  = {DATA_W{1'b0}};
            dv0_s = 1'b0;
            er0_s = 1'b0;
        end
    end

    // Frame bookkeeping; wait_low_r blocks restarts until tx_en has been seen low
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wait_low_r  <= 1'b1;
            drop_pend_r <= 1'b0;
            beat_r      <= CNT_ZERO;
            inj_arm_r   <= 1'b0;
            inj_idx_r   <= CNT_ZERO;
            inj_mask_r  <= {DATA_W{1'b0}};
            inj_flag_r  <= 1'b0;
        end else begin
            if (!tx_en_i) begin
                wait_low_r <= 1'b0;
            end else if (start_s && !en_i) begin
                wait_low_r <= 1'b1;
            end
            drop_pend_r <= (drop_pend_r && !start_drop_s) || drop_i;
            if (tx_en_i) begin
                beat_r <= sat_inc(idx_s);
            end
            if (start_pass_s) begin
                inj_arm_r  <= inj_en_i && !hit_s;
                inj_idx_r  <= inj_idx_i;
                inj_mask_r <= inj_mask_i;
                inj_flag_r <= inj_flag_i;
            end else if (hit_s) begin
                inj_arm_r <= 1'b0;
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            frame_cnt_r <= CNT_ZERO;
            drop_cnt_r  <= CNT_ZERO;
            err_cnt_r   <= CNT_ZERO;
        end else begin
            if (start_pass_s) begin
                frame_cnt_r <= sat_inc(frame_cnt_r);
            end
            if (start_drop_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
            if (hit_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
        end
    end

    // Delay line; the last stage drives the RX pins directly
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe_r[i] <= {(DATA_W+2){1'b0}};
            end
        end else begin
            pipe_r[0] <= {dv0_s, er0_s, d0_s};
            for (int i = 1; i < DELAY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign rx_dv_o     = pipe_r[DELAY-1][DATA_W+1];
    assign rx_er_o     = pipe_r[DELAY-1][DATA_W];
    assign rx_d_o      = pipe_r[DELAY-1][DATA_W-1:0];
    assign frame_cnt_o = frame_cnt_r;
    assign drop_cnt_o  = drop_cnt_r;
    assign err_cnt_o   = err_cnt_r;

endmodule

// File: tb/tb_iob_eth_mii_loopback.sv
// Randomised bench for iob_eth_mii_loopback: two instances (MII/DELAY=1/CNT_W=16 and
// GMII/DELAY=5/CNT_W=2) checked every cycle against a frame-level reference model.
module tb_iob_eth_mii_loopback;
    localparam int N       = 4000;
    localparam int DIR_END = 140;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n, en, tx_en, tx_er, drop, inj_en, inj_flag;
    logic [7:0]  tx_d, inj_mask;
    logic [15:0] inj_idx;
    logic [3:0]  rx_d_a;
    logic        rx_dv_a, rx_er_a;
    logic [15:0] fc_a, dc_a, ec_a;
    logic [7:0]  rx_d_b;
    logic        rx_dv_b, rx_er_b;
    logic [1:0]  fc_b, dc_b, ec_b;

    iob_eth_mii_loopback #(.DATA_W(4), .DELAY(1), .CNT_W(16)) dut_a (
        .clk_i(clk), .arst_n_i(arst_n), .en_i(en), .tx_d_i(tx_d[3:0]), .tx_en_i(tx_en),
        .tx_er_i(tx_er), .drop_i(drop), .inj_en_i(inj_en), .inj_idx_i(inj_idx),
        .inj_mask_i(inj_mask[3:0]), .inj_flag_i(inj_flag), .rx_d_o(rx_d_a), .rx_dv_o(rx_dv_a),
        .rx_er_o(rx_er_a), .frame_cnt_o(fc_a), .drop_cnt_o(dc_a), .err_cnt_o(ec_a));

    iob_eth_mii_loopback #(.DATA_W(8), .DELAY(5), .CNT_W(2)) dut_b (
        .clk_i(clk), .arst_n_i(arst_n), .en_i(en), .tx_d_i(tx_d), .tx_en_i(tx_en),
        .tx_er_i(tx_er), .drop_i(drop), .inj_en_i(inj_en), .inj_idx_i(inj_idx[1:0]),
        .inj_mask_i(inj_mask), .inj_flag_i(inj_flag), .rx_d_o(rx_d_b), .rx_dv_o(rx_dv_b),
        .rx_er_o(rx_er_b), .frame_cnt_o(fc_b), .drop_cnt_o(dc_b), .err_cnt_o(ec_b));

    // stimulus timeline, one entry per clock cycle
    bit          st_rst[N], st_txen[N], st_txer[N], st_en[N], st_drop[N], st_injen[N], st_flag[N];
    logic [7:0]  st_txd[N], st_mask[N];
    logic [15:0] st_idx[N];
    // model scratch and expected outputs per instance
    logic [7:0]  s0_d[N];
    bit          s0_v[N], s0_e[N], ev_f[N], ev_d[N], ev_e[N];
    logic [7:0]  exp_d[2][N];
    bit          exp_v[2][N], exp_e[2][N];
    int          exp_fc[2][N], exp_dc[2][N], exp_ec[2][N];
    int          n_vec = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, t, act, expv);
        end
    endtask

    task automatic frame(input int s, input int len);
        for (int b = 0; b < len; b++) st_txen[s+b] = 1'b1;
    endtask

    task automatic gen_stim();
        int t, len;
        for (int c = 0; c < N; c++) begin
            st_rst[c] = 1'b0; st_txen[c] = 1'b0; st_txer[c] = 1'b0; st_en[c] = 1'b1;
            st_drop[c] = 1'b0; st_injen[c] = 1'b0; st_flag[c] = 1'b0;
            st_txd[c] = 8'($urandom); st_mask[c] = 8'($urandom); st_idx[c] = 16'($urandom_range(0, 45));
        end
        st_rst[0] = 1'b1; st_rst[1] = 1'b1; st_rst[2] = 1'b1;
        frame(5, 20);
        for (int b = 0; b < 20; b++) st_txd[5+b] = 8'(5 + (b % 9));
        st_en[12] = 1'b0; st_injen[10] = 1'b1; st_idx[10] = 16'd2;
        frame(27, 20);
        st_injen[27] = 1'b1; st_idx[27] = 16'd3; st_mask[27] = 8'h0F; st_flag[27] = 1'b1;
        st_txd[30] = {st_txd[30][7:4], 4'hA};
        frame(49, 20);
        st_injen[49] = 1'b1; st_idx[49] = 16'd100; st_mask[49] = 8'hFF; st_flag[49] = 1'b1;
        frame(71, 10); st_drop[75] = 1'b1;
        frame(83, 10);
        frame(95, 10);
        frame(107, 8); st_en[107] = 1'b0;
        frame(117, 10); st_rst[121] = 1'b1; st_rst[122] = 1'b1;
        frame(128, 6);
        t = DIR_END;
        while (t < N) begin
            t += $urandom_range(1, 3);
            len = $urandom_range(1, 40);
            for (int b = 0; b < len && t + b < N; b++) st_txen[t+b] = 1'b1;
            t += len;
        end
        for (int c = DIR_END; c < N; c++) begin
            st_en[c]    = ($urandom_range(0, 9) != 0);
            st_drop[c]  = ($urandom_range(0, 29) == 0);
            st_injen[c] = ($urandom_range(0, 1) == 1);
            st_flag[c]  = ($urandom_range(0, 1) == 1);
            st_txer[c]  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) st_idx[c] = 16'(100 + $urandom_range(0, 200));
            if ($urandom_range(0, 599) == 0 && c + 1 < N) begin
                st_rst[c] = 1'b1; st_rst[c+1] = 1'b1;
            end
        end
    endtask

    // Frame-level reference: each maximal tx_en run is one frame, classified at its first cycle
    task automatic build_model(input int k, input int dl, input int cw);
        int cmax, last_clear, len, tgt, fc, dc, ec, src;
        bit pend, clean;
        logic [7:0] dmask;
        cmax = (1 << cw) - 1;
        dmask = (k == 0) ? 8'h0F : 8'hFF;
        last_clear = -1;
        for (int t = 0; t < N; t++) begin
            s0_d[t] = 8'h00; s0_v[t] = 1'b0; s0_e[t] = 1'b0;
            ev_f[t] = 1'b0; ev_d[t] = 1'b0; ev_e[t] = 1'b0;
        end
        for (int t = 0; t < N; t++) begin
            if (st_rst[t]) begin
                last_clear = t;
            end else if (t > 0 && st_txen[t] && !st_txen[t-1] && !st_rst[t-1] && st_en[t]) begin
                len = 0;
                while (t + len < N && st_txen[t+len] && !st_rst[t+len]) len++;
                pend = 1'b0;
                for (int c = last_clear + 1; c < t; c++) if (st_drop[c]) pend = 1'b1;
                if (pend) begin
                    ev_d[t] = 1'b1;
                    last_clear = t - 1;
                end else begin
                    ev_f[t] = 1'b1;
                    for (int b = 0; b < len; b++) begin
                        s0_d[t+b] = st_txd[t+b] & dmask; s0_v[t+b] = 1'b1; s0_e[t+b] = st_txer[t+b];
                    end
                    tgt = int'(st_idx[t]) & cmax;
                    if (st_injen[t] && tgt < len) begin
                        s0_d[t+tgt] = s0_d[t+tgt] ^ (st_mask[t] & dmask);
                        s0_e[t+tgt] = s0_e[t+tgt] | st_flag[t];
                        ev_e[t+tgt] = 1'b1;
                    end
                end
            end
        end
        fc = 0; dc = 0; ec = 0;
        for (int t = 0; t < N; t++) begin
            if (st_rst[t]) begin
                fc = 0; dc = 0; ec = 0;
            end else begin
                if (ev_f[t] && fc < cmax) fc++;
                if (ev_d[t] && dc < cmax) dc++;
                if (ev_e[t] && ec < cmax) ec++;
            end
            exp_fc[k][t] = fc; exp_dc[k][t] = dc; exp_ec[k][t] = ec;
            src = t - dl + 1;
            clean = (src >= 0);
            for (int c = (src < 0 ? 0 : src); c <= t; c++) if (st_rst[c]) clean = 1'b0;
            if (clean) begin
                exp_d[k][t] = s0_d[src]; exp_v[k][t] = s0_v[src]; exp_e[k][t] = s0_e[src];
            end else begin
                exp_d[k][t] = 8'h00; exp_v[k][t] = 1'b0; exp_e[k][t] = 1'b0;
            end
        end
    endtask

    task automatic apply(input int t);
        arst_n = !st_rst[t]; en = st_en[t]; tx_en = st_txen[t]; tx_er = st_txer[t];
        tx_d = st_txd[t]; drop = st_drop[t]; inj_en = st_injen[t]; inj_idx = st_idx[t];
        inj_mask = st_mask[t]; inj_flag = st_flag[t];
    endtask

    initial begin
        gen_stim();
        build_model(0, 1, 16);
        build_model(1, 5, 2);
        apply(0);
        for (int t = 1; t < N; t++) begin
            @(negedge clk);
            #1;
            apply(t);
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Compare process: cycle ci is sampled on the falling edge after rising edge ci
    initial begin
        for (int ci = 0; ci < N; ci++) begin
            @(negedge clk);
            chk("a_rx_d", ci, 32'(rx_d_a), 32'(exp_d[0][ci]));
            chk("a_rx_dv", ci, 32'(rx_dv_a), 32'(exp_v[0][ci]));
            chk("a_rx_er", ci, 32'(rx_er_a), 32'(exp_e[0][ci]));
            chk("a_frame_cnt", ci, 32'(fc_a), 32'(exp_fc[0][ci]));
            chk("a_drop_cnt", ci, 32'(dc_a), 32'(exp_dc[0][ci]));
            chk("a_err_cnt", ci, 32'(ec_a), 32'(exp_ec[0][ci]));
            chk("b_rx_d", ci, 32'(rx_d_b), 32'(exp_d[1][ci]));
            chk("b_rx_dv", ci, 32'(rx_dv_b), 32'(exp_v[1][ci]));
            chk("b_rx_er", ci, 32'(rx_er_b), 32'(exp_e[1][ci]));
            chk("b_frame_cnt", ci, 32'(fc_b), 32'(exp_fc[1][ci]));
            chk("b_drop_cnt", ci, 32'(dc_b), 32'(exp_dc[1][ci]));
            chk("b_err_cnt", ci, 32'(ec_b), 32'(exp_ec[1][ci]));
            case (ci)
                2:   begin chk("lit_reset_dv", ci, 32'(rx_dv_a), 32'd0); chk("lit_reset_fc", ci, 32'(fc_a), 32'd0); end
                5:   begin chk("lit_f1_d", ci, 32'(rx_d_a), 32'd5); chk("lit_f1_dv", ci, 32'(rx_dv_a), 32'd1); end
                8:   chk("lit_lat_b_pre", ci, 32'(rx_dv_b), 32'd0);
                9:   begin chk("lit_lat_b_first", ci, 32'(rx_dv_b), 32'd1); chk("lit_lat_b_data", ci, 32'(rx_d_b), 32'd5); end
                25:  begin chk("lit_f1_fc", ci, 32'(fc_a), 32'd1); chk("lit_f1_end_dv", ci, 32'(rx_dv_a), 32'd0); end
                28:  chk("lit_lat_b_last", ci, 32'(rx_dv_b), 32'd1);
                29:  begin chk("lit_lat_b_fall", ci, 32'(rx_dv_b), 32'd0); chk("lit_inj_pre_er", ci, 32'(rx_er_a), 32'd0); end
                30:  begin
                         chk("lit_inj_d", ci, 32'(rx_d_a), 32'd5); chk("lit_inj_er", ci, 32'(rx_er_a), 32'd1);
                         chk("lit_inj_ec", ci, 32'(ec_a), 32'd1);
                     end
                31:  chk("lit_inj_once_er", ci, 32'(rx_er_a), 32'd0);
                70:  chk("lit_oor_ec", ci, 32'(ec_a), 32'd1);
                85:  begin chk("lit_drop_dv", ci, 32'(rx_dv_a), 32'd0); chk("lit_drop_dc", ci, 32'(dc_a), 32'd1); end
                106: begin
                         chk("lit_fc_a", ci, 32'(fc_a), 32'd5); chk("lit_dc_a", ci, 32'(dc_a), 32'd1);
                         chk("lit_sat_fc_b", ci, 32'(fc_b), 32'd3);
                     end
                110: chk("lit_en0_dv", ci, 32'(rx_dv_a), 32'd0);
                115: chk("lit_en0_fc", ci, 32'(fc_a), 32'd5);
                121: begin
                         chk("lit_rst_mid_dv", ci, 32'(rx_dv_a), 32'd0); chk("lit_rst_mid_fc", ci, 32'(fc_a), 32'd0);
                         chk("lit_rst_mid_dv_b", ci, 32'(rx_dv_b), 32'd0);
                     end
                124: chk("lit_no_resume_dv", ci, 32'(rx_dv_a), 32'd0);
                128: begin chk("lit_resume_dv", ci, 32'(rx_dv_a), 32'd1); chk("lit_resume_fc", ci, 32'(fc_a), 32'd1); end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/iob_eth_mii_loopback.md
# iob_eth_mii_loopback

Parametrised MII/GMII loopback channel model for the Ethernet simulation wrapper. It replaces the fixed one-register TX-to-RX path with a configurable-width, configurable-latency delay line. It adds frame-level drop, single-beat error injection and statistics counters, so MAC receive-path error handling can be exercised in simulation. It sits between the MAC TX pins and RX pins, and both sides are clocked by the Ethernet clock.

## Interface
Parameters:
- DATA_W, 4, data beat width (4 = MII, 8 = GMII); must be ≥1.
- DELAY, 1, TX-to-RX latency in clock cycles; must be ≥1. DELAY=1 reproduces the legacy single-register loopback.
- CNT_W, 16, width of the beat index and the statistics counters.

Ports:
- clk_i  in  1  Ethernet clock; all logic on the rising edge.
- arst_n_i  in  1  reset, asynchronous, active-low.
- en_i  in  1  loopback enable; sampled only at frame start.
- tx_d_i  in  DATA_W  MAC transmit data.
- tx_en_i  in  1  MAC transmit enable (frame envelope).
- tx_er_i  in  1  MAC transmit error.
- drop_i  in  1  pulse: request that the next frame be dropped.
- inj_en_i  in  1  arm error injection; sampled at frame start.
- inj_idx_i  in  CNT_W  beat index within the frame to corrupt; beat 0 is the first beat with tx_en_i=1.
- inj_mask_i  in  DATA_W  XOR mask applied to the corrupted beat.
- inj_flag_i  in  1  also assert rx_er_o on the corrupted beat; sampled at frame start.
- rx_d_o  out  DATA_W  looped-back receive data.
- rx_dv_o  out  1  receive data valid.
- rx_er_o  out  1  receive error.
- frame_cnt_o  out  CNT_W  frames passed.
- drop_cnt_o  out  CNT_W  frames dropped.
- err_cnt_o  out  CNT_W  frames in which a beat was corrupted.

## Operation
- **Input-side FSM states:** IDLE, PASS, DROP.
- **Frame start:** a cycle with the FSM in IDLE and tx_en_i=1.
- **IDLE, en_i=0:** the FSM stays in IDLE. Outputs carry dv=0, er=0, d=0. The frame is ignored until tx_en_i falls and rises again; tx_en_i must return to 0 before a new start is recognised.
- **IDLE, en_i=1 at frame start:**
  - If drop is pending: go to DROP and clear the pending flag.
  - Otherwise: go to PASS and latch inj_en_i, inj_idx_i, inj_mask_i and inj_flag_i for this frame.
  - The beat counter loads 0 for the start beat.
- **Beat counter:** increments on each tx_en_i=1 beat and saturates at 2^CNT_W−1.
- **PASS:**
  - Stage-0 output is d=tx_d_i, dv=1, er=tx_er_i.
  - If injection is armed and the beat index equals the latched index: d=tx_d_i^mask, er=tx_er_i|flag, and err_cnt increments once for the frame.
  - On tx_en_i=0, return to IDLE; that beat carries dv=0.
- **DROP:** stage-0 output is all zero for every beat. Return to IDLE when tx_en_i=0.
- **Drop requests:**
  - drop_i=1 in any cycle sets the sticky pending flag.
  - A pulse during a frame applies to the following frame.
  - drop_i at the frame-start cycle itself does not affect that frame.
- **Injection out of range:** if the latched index is ≥ the frame length, nothing is corrupted and err_cnt does not increment.
- **Mid-frame input changes:** en_i or inj_* changing mid-frame have no effect until the next frame start.
- **Counter increments:** frame_cnt at a PASS start, drop_cnt at a DROP start, err_cnt on the corrupted beat. All counters saturate at all-ones and never wrap.
- **Delay line:** the stage-0 tuple (d, dv, er) passes through DELAY register stages to rx_*_o.

## Timing
- **Reset:** all outputs are 0, every delay stage is cleared, the FSM is in IDLE, the drop-pending flag is cleared and all counters are 0.
- **Reset mid-frame:** the frame is discarded, no partial output is emitted after release, and the next frame start must see tx_en_i low first.
- **Latency:** an input beat sampled at edge t appears on rx_*_o after edge t+DELAY−1; that is, it is registered DELAY times and the output is fully registered.
- **Counter update:** visible on the counter outputs one cycle after the triggering beat's edge.
- **Back-to-back frames:** frames separated by a single tx_en_i=0 cycle are handled, with that cycle emitting dv=0.
- **Simultaneous events:** drop_i together with a pending flag is idempotent. A drop and a saturated counter together leave the counter unchanged.

## Test plan
- **Basic loopback:** DATA_W=4, DELAY=1, en_i=1. Send a 20-beat frame, nibbles 0x5…0xD. Required: rx_d_o/rx_dv_o reproduce the frame exactly 1 cycle later, frame_cnt_o=1, other counters 0.
- **Latency and width:** DATA_W=8, DELAY=5. Send a 64-byte frame. Required: the first rx_dv_o=1 occurs 5 cycles after the first tx_en_i=1, the data is bit-exact, and dv falls 5 cycles after tx_en_i falls.
- **Error injection:**
  - inj_en_i=1, inj_idx_i=3, inj_mask_i=0xF, inj_flag_i=1, beat 3 data 0xA. Required: rx_d_o=0x5 with rx_er_o=1 on that beat only, err_cnt_o=1.
  - Repeat with inj_idx_i=100 on a 20-beat frame. Required: no corruption, err_cnt_o stays 1.
- **Drop:** pulse drop_i during frame 1, then send frames 2 and 3. Required: frame 1 passes, frame 2 produces no rx_dv_o, frame 3 passes; frame_cnt_o=2, drop_cnt_o=1.
- **Enable and reset:** deassert en_i before a frame. Required: no output and no count. Assert arst_n_i=0 mid-frame with en_i=1. Required: all outputs 0 immediately, counters 0, and no resumption until tx_en_i toggles low then high.
- **Saturation:** CNT_W=2, send 5 frames. Required: frame_cnt_o holds at 3.
